// File: rtl/gray_seq_gen.sv
// Prescaled up/down Gray-code sequence generator, modulo LIMIT+1, with parallel
// load and a valid/ready output handshake. All outputs are registered.
module gray_seq_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 9,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap
);

  localparam int unsigned     PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] LIM     = WIDTH'(LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin, bin_nxt, bin_inc, bin_dec;
  logic [PW-1:0]    pre, pre_nxt;
  logic             stall, xfer, step;
  logic             valid_nxt, wrap_nxt;

  always_comb begin
    stall   = out_valid & ~out_ready;
    xfer    = out_valid & out_ready;
    // A stalled code blocks the step; pre then saturates at its last value.
    step    = en && (pre == PRE_LAST) && !stall;

    pre_nxt = pre;
    if (load) begin
      pre_nxt = '0;
    end else if (en && (pre != PRE_LAST)) begin
      pre_nxt = pre + 1'b1;
    end else if (step) begin
      pre_nxt = '0;
    end

    bin_inc   = (bin == LIM) ? '0 : bin + 1'b1;
    bin_dec   = (bin == '0) ? LIM : bin - 1'b1;
    bin_nxt   = bin;
    valid_nxt = stall;
    wrap_nxt  = 1'b0;
    if (load) begin
      bin_nxt   = (load_val > LIM) ? LIM : load_val;
      valid_nxt = 1'b1;
    end else if (step) begin
      bin_nxt   = dir ? bin_inc : bin_dec;
      wrap_nxt  = dir ? (bin == LIM) : (bin == '0);
      valid_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (stall) begin
          state_nxt = HOLD;
        end
      end
      HOLD: if (xfer) state_nxt = en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= '0;
      pre       <= '0;
      gray_out  <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin       <= bin_nxt;
      pre       <= pre_nxt;
      gray_out  <= bin_nxt ^ (bin_nxt >> 1);
      out_valid <= valid_nxt;
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_seq_gen.sv
// Self-checking bench for gray_seq_gen: directed scenarios plus randomized
// stimulus, compared every cycle against an arithmetic reference model.
module tb_gray_seq_gen;

  localparam int WIDTH = 4;
  localparam int LIMIT = 9;
  localparam int DIV   = 4;
  localparam int EXP_UP [10] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 0};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] gray_out;
  logic             out_valid;
  logic             wrap;

  int n_tests = 0;
  int n_fail  = 0;

  int m_bin = 0, m_pre = 0, m_valid = 0, m_gray = 0, m_wrap = 0;
  int got_c[$], got_w[$], got_t[$];

  gray_seq_gen #(
    .WIDTH(WIDTH),
    .LIMIT(LIMIT),
    .DIV  (DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .gray_out (gray_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: count modulo LIMIT+1, Gray = b ^ (b >> 1), prescaler by cycle count.
  task automatic model_step();
    bit stalled, hs, stepped;
    if (!rst_n) begin
      m_bin = 0; m_pre = 0; m_valid = 0; m_gray = 0; m_wrap = 0;
      return;
    end
    stalled = (m_valid != 0) && !out_ready;
    hs      = (m_valid != 0) && out_ready;
    stepped = 0;
    if (en) begin
      if (m_pre == DIV - 1) begin
        if (!stalled) begin
          stepped = 1;
          m_pre   = 0;
        end
      end else begin
        m_pre++;
      end
    end
    if (load) begin
      m_bin   = (int'(load_val) > LIMIT) ? LIMIT : int'(load_val);
      m_pre   = 0;
      m_valid = 1;
      m_wrap  = 0;
    end else if (stepped) begin
      if (dir) begin
        m_wrap = (m_bin == LIMIT) ? 1 : 0;
        m_bin  = (m_bin + 1) % (LIMIT + 1);
      end else begin
        m_wrap = (m_bin == 0) ? 1 : 0;
        m_bin  = (m_bin + LIMIT) % (LIMIT + 1);
      end
      m_valid = 1;
    end else begin
      m_wrap = 0;
      if (hs) m_valid = 0;
    end
    m_gray = m_bin ^ (m_bin >> 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("gray", 32'(gray_out), m_gray);
    check("valid", 32'(out_valid), m_valid);
    check("wrap", 32'(wrap), m_wrap);
  endtask

  task automatic run_collect(input int n);
    got_c.delete();
    got_w.delete();
    got_t.delete();
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (out_valid) begin
        got_c.push_back(int'(gray_out));
        got_w.push_back(int'(wrap));
        got_t.push_back(i);
      end
    end
  endtask

  initial begin
    // Reset held with en and load asserted: nothing may leak through.
    rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5; dir = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_gray", 32'(gray_out), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_wrap", 32'(wrap), 0);
    end

    // Up sweep over a full period.
    rst_n = 1'b1; load = 1'b0;
    run_collect(10 * DIV);
    check("up_count", got_c.size(), 10);
    if (got_t.size() > 0) check("first_step_edge", got_t[0], DIV);
    for (int i = 0; i < 10; i++) begin
      if (i < got_c.size()) begin
        check($sformatf("up_code%0d", i), got_c[i], EXP_UP[i]);
        check($sformatf("up_wrap%0d", i), got_w[i], (i == 9) ? 1 : 0);
      end
    end

    // Down from 0 wraps to LIMIT.
    dir = 1'b0;
    run_collect(2 * DIV);
    check("down_count", got_c.size(), 2);
    if (got_c.size() == 2) begin
      check("down_code0", got_c[0], 13);
      check("down_wrap0", got_w[0], 1);
      check("down_code1", got_c[1], 12);
      check("down_wrap1", got_w[1], 0);
    end

    // Backpressure: hold 0011 for 20 cycles, then release.
    rst_n = 1'b0; dir = 1'b1;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * DIV; i++) cycle();
    check("bp_start", 32'(gray_out), 3);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("bp_hold_gray", 32'(gray_out), 3);
      check("bp_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_release_gray", 32'(gray_out), 2);
    check("bp_release_valid", 32'(out_valid), 1);

    // Load clamp while stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    load = 1'b1; load_val = 4'd12;
    cycle();
    check("load_gray", 32'(gray_out), 13);
    check("load_valid", 32'(out_valid), 1);
    check("load_wrap", 32'(wrap), 0);
    load = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DIV - 1; i++) cycle();
    check("post_load_idle", 32'(out_valid), 0);
    cycle();
    check("post_load_gray", 32'(gray_out), 0);
    check("post_load_wrap", 32'(wrap), 1);

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) cycle();
    rst_n = 1'b0;
    cycle();
    check("midrst_gray", 32'(gray_out), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_wrap", 32'(wrap), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < DIV - 1; i++) cycle();
    check("midrst_no_early", 32'(out_valid), 0);
    cycle();
    check("midrst_restart", 32'(gray_out), 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      en        = ($urandom_range(0, 7) != 0);
      dir       = 1'($urandom_range(0, 1));
      load      = ($urandom_range(0, 19) == 0);
      load_val  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_seq_gen.md
# gray_seq_gen

Registered 4-bit Gray-code sequence generator. It sits directly upstream of the Gray-to-binary converter and feeds that converter's Gray input. It steps a modulo-(LIMIT+1) count in Gray order at a prescaled rate, with up/down direction and parallel load. Each new code is offered on a valid/ready handshake so the consumer can stall the sequence.

## Interface
- WIDTH, 4: code width in bits.
- LIMIT, 9: highest binary value in the sequence; the count wraps LIMIT↔0. Legal range 1..2^WIDTH-1.
- DIV, 4: clock cycles per step while enabled. Must be ≥1.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- en  in  1  step enable; 0 freezes the prescaler and the count.
- dir  in  1  1 = count up, 0 = count down; sampled at the step event.
- load  in  1  single-cycle load strobe.
- load_val  in  WIDTH  binary value to load.
- gray_out  out  WIDTH  registered Gray code, equal to bin ^ (bin >> 1).
- out_valid  out  1  gray_out holds a code not yet accepted.
- out_ready  in  1  consumer accepts gray_out when out_valid is also 1.
- wrap  out  1  one-cycle pulse, registered alongside the gray_out update that crossed LIMIT↔0.

## Operation
- State: binary count bin[WIDTH-1:0], prescaler pre (0..DIV-1), and FSM {IDLE, RUN, HOLD}.
- Reset (rst_n=0 at an edge):
  - bin=0, pre=0, FSM=IDLE.
  - gray_out=0, out_valid=0, wrap=0.
  - Reset overrides all inputs, including mid-HOLD.
- FSM transitions:
  - IDLE → RUN when en=1.
  - RUN → IDLE when en=0. pre keeps its value and is not cleared.
  - RUN → HOLD when a step or load sets out_valid and out_ready=0 on the following cycle.
  - HOLD → RUN on handshake (out_valid & out_ready).
  - HOLD → IDLE on handshake with en=0.
- Prescaler:
  - In RUN with en=1: pre increments. At pre==DIV-1 a step event fires and pre returns to 0.
  - If out_valid=1 and out_ready=0 when pre==DIV-1, pre saturates at DIV-1 and no step fires.
- Step event:
  - bin ← bin+1 when dir=1. From LIMIT it goes to 0 and wrap=1.
  - bin ← bin-1 when dir=0. From 0 it goes to LIMIT and wrap=1.
  - gray_out is updated and out_valid is set to 1.
  - The wrap step (9→0 Gray 1101→0000) is not a single-bit change. This is intended.
- Handshake:
  - A transfer occurs in any cycle with out_valid & out_ready.
  - out_valid clears on the next edge unless a step or load occurs in that same cycle; in that case out_valid stays 1 with the new code.
  - While out_valid=1 and out_ready=0, gray_out and wrap are held stable (wrap stays low after its pulse).
- Load:
  - Load has priority over a step in the same cycle and works in any state, including with en=0.
  - bin ← min(load_val, LIMIT), pre ← 0, gray_out updated, out_valid=1, wrap=0.
  - A pending unaccepted code is overwritten and discarded.
- wrap is high for exactly one cycle per wrapping step and is 0 otherwise.

## Timing
- After reset with en=1 held, the first step is registered at the DIV-th edge with en=1. gray_out and out_valid change on that edge.
- Steady state with out_ready=1: one new code every DIV cycles. Each code is valid for 1 cycle when DIV>1, and out_valid stays continuously high when DIV=1.
- Load latency: 1 cycle. The value is visible on the edge that samples load=1.
- Stall release: when out_ready rises while pre is saturated at DIV-1, the next step fires in that handshake cycle. The new code appears on the next edge with out_valid kept at 1.
- dir and load_val are sampled only at step/load edges. Changing them at other times has no effect.
- Every output is a register. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with en=1 and load=1 → gray_out=0000, out_valid=0, wrap=0 throughout. No step occurs until DIV cycles after rst_n=1.
- Up sweep: DIV=4, LIMIT=9, dir=1, out_ready=1 → codes every 4 cycles: 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 0000. wrap=1 only with 0000.
- Down wrap: from bin=0 with dir=0 → next code 1101 (bin 9) with wrap=1, then 1100.
- Backpressure:
  - Set out_ready=0 for 20 cycles once 0011 is valid → gray_out stays 0011 and out_valid stays 1, with no step.
  - Raise out_ready → handshake, then 0010 on the next edge with out_valid still 1.
- Load clamp: in HOLD, load=1 with load_val=12 → next edge gray_out=1101, out_valid=1, wrap=0, pre=0. The old code is discarded. The first step after that comes DIV cycles later.
- Mid-operation reset: rst_n=0 for one cycle during HOLD → next edge all outputs are 0 and the FSM is IDLE. The sequence restarts from 0001.
